csi2rx_seven_lane_lml: RTL

Receive-side lane merging for 7-lane CSI-2 operation, the counterpart of the 7-lane transmit distributor. Takes per-lane HS bytes from the D-PHY PPI receivers and extracts the 32-bit packet header. Repacks payload and CRC bytes from 56-bit lane words into 64-bit little-endian words and writes them into the receive byte FIFO. Sits between the PPI receive lanes and the CSI-2 RX packet/ECC layer.

---
 rtl/csi2rx_seven_lane_lml_pkg.sv | 21 ++
 rtl/csi2rx_seven_lane_lml_byte_packer.sv | 84 ++++++++
 rtl/csi2rx_seven_lane_lml.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/csi2rx_seven_lane_lml_pkg.sv
// rtl/csi2rx_seven_lane_lml_pkg.sv - shared constants and FSM encoding for 7-lane CSI-2 RX lane merge
package csi2rx_seven_lane_lml_pkg;

    localparam int               CSI2_LANES        = 7;
    localparam logic [5:0]       CSI2_SHORT_DI_MAX = 6'h0F;
    localparam int               CSI2_CRC_BYTES    = 2;
    localparam logic [CSI2_LANES-1:0] SYNC_ALL     = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_PAYLOAD   = 2'd2,
        ST_EOP_WAIT  = 2'd3
    } lml_state_t;

    // Bytes to take this cycle: the lane capacity, clipped to what the packet still owes.
    function automatic logic [2:0] take_bytes(input logic [16:0] rem, input logic [2:0] cap);
        return (rem >= 17'(cap)) ? cap : rem[2:0];
    endfunction

endpackage

// File: rtl/csi2rx_seven_lane_lml_byte_packer.sv
// rtl/csi2rx_seven_lane_lml_byte_packer.sv - 56-bit lane word to 64-bit little-endian FIFO word packer
module csi2rx_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_append,
    input  logic        i_flush,
    input  logic [2:0]  i_cnt,
    input  logic [55:0] i_data,
    output logic        o_wr_en,
    output logic [63:0] o_wr_data,
    output logic [3:0]  o_wr_bytes,
    output logic        o_wr_last
);

    logic [55:0]  r_buf;
    logic [2:0]   r_phase;
    logic         r_pend;
    logic         r_wr_en;
    logic [63:0]  r_wr_data;
    logic [3:0]   r_wr_bytes;
    logic         r_wr_last;

    logic [55:0]  w_data_m;
    logic [111:0] w_comb;
    logic [3:0]   w_total;

    assign w_data_m = i_data & 56'((64'd1 << {i_cnt, 3'b000}) - 64'd1);
    assign w_comb   = {56'd0, r_buf} | ({56'd0, w_data_m} << {r_phase, 3'b000});
    assign w_total  = {1'b0, r_phase} + {1'b0, i_cnt};

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_buf      <= '0;
            r_phase    <= '0;
            r_pend     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_wr_bytes <= '0;
            r_wr_last  <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_wr_bytes <= '0;
            r_wr_last  <= 1'b0;
            if (r_pend) begin
                // Residue left behind by a full word written in the packet's final cycle.
                r_wr_en    <= 1'b1;
                r_wr_data  <= {8'd0, r_buf};
                r_wr_bytes <= {1'b0, r_phase};
                r_wr_last  <= 1'b1;
                r_buf      <= '0;
                r_phase    <= '0;
                r_pend     <= 1'b0;
            end else if (i_append) begin
                if (w_total >= 4'd8) begin
                    r_wr_en    <= 1'b1;
                    r_wr_data  <= w_comb[63:0];
                    r_wr_bytes <= 4'd8;
                    r_wr_last  <= i_flush && (w_total == 4'd8);
                    r_buf      <= {8'd0, w_comb[111:64]};
                    r_phase    <= 3'(w_total - 4'd8);
                    r_pend     <= i_flush && (w_total != 4'd8);
                end else if (i_flush) begin
                    r_wr_en    <= 1'b1;
                    r_wr_data  <= w_comb[63:0];
                    r_wr_bytes <= w_total;
                    r_wr_last  <= 1'b1;
                    r_buf      <= '0;
                    r_phase    <= '0;
                end else begin
                    r_buf      <= w_comb[55:0];
                    r_phase    <= w_total[2:0];
                end
            end
        end
    end

    assign o_wr_en    = r_wr_en;
    assign o_wr_data  = r_wr_data;
    assign o_wr_bytes = r_wr_bytes;
    assign o_wr_last  = r_wr_last;

endmodule

// File: rtl/csi2rx_seven_lane_lml.sv
// rtl/csi2rx_seven_lane_lml.sv - 7-lane CSI-2 RX lane merge: header capture, payload repack, error pulses
module csi2rx_seven_lane_lml
    import csi2rx_seven_lane_lml_pkg::*;
(
    input  logic        rxbyteclkhs,
    input  logic        rxbyteclkhs_rst,
    input  logic        seven_lane_en,
    input  logic [6:0]  rxactivehs,
    input  logic [6:0]  rxsynchs,
    input  logic [6:0]  rxvalidhs,
    input  logic [55:0] rxdatahs,
    output logic        header_valid,
    output logic [31:0] header_data,
    output logic        fifo_wr_en,
    output logic [63:0] fifo_wr_data,
    output logic [3:0]  fifo_wr_bytes,
    output logic        fifo_wr_last,
    output logic        packet_done,
    output logic        sync_err,
    output logic        lane_err
);

    lml_state_t  r_state;
    lml_state_t  w_next;
    logic [16:0] r_rem;
    logic [16:0] w_rem_nxt;
    logic [31:0] r_header;
    logic        r_hdr_valid;
    logic        r_short_done;
    logic        r_sync_err;
    logic        r_lane_err;

    logic        w_hdr_load;
    logic        w_short;
    logic        w_sync_err;
    logic        w_lane_err;
    logic        w_append;
    logic        w_flush;
    logic        w_clear;
    logic [2:0]  w_cnt;
    logic [55:0] w_app_data;
    logic        w_sync_bad;
    logic [16:0] w_hdr_rem;
    logic        w_pk_last;
    logic        w_unused;

    assign w_sync_bad = (rxsynchs != 7'h00) && (rxsynchs != SYNC_ALL);
    assign w_hdr_rem  = {1'b0, rxdatahs[23:16], rxdatahs[15:8]} + 17'(CSI2_CRC_BYTES);
    assign w_unused   = ^{rxactivehs[6:1], rxvalidhs[6:1], rxdatahs[7:6]};

    always_comb begin
        w_next     = r_state;
        w_rem_nxt  = r_rem;
        w_hdr_load = 1'b0;
        w_short    = 1'b0;
        w_sync_err = 1'b0;
        w_lane_err = 1'b0;
        w_append   = 1'b0;
        w_flush    = 1'b0;
        w_clear    = 1'b0;
        w_cnt      = 3'd0;
        w_app_data = '0;
        case (r_state)
            ST_IDLE: begin
                w_sync_err = w_sync_bad;
                if (seven_lane_en && rxactivehs[0]) w_next = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                if (rxsynchs == SYNC_ALL) begin
                    w_hdr_load = 1'b1;
                    if (rxdatahs[5:0] <= CSI2_SHORT_DI_MAX) begin
                        w_short = 1'b1;
                        w_next  = ST_EOP_WAIT;
                    end else begin
                        // Lanes 4..6 of the sync cycle already carry the first payload bytes.
                        w_cnt      = take_bytes(w_hdr_rem, 3'd3);
                        w_append   = 1'b1;
                        w_app_data = {32'd0, rxdatahs[55:32]};
                        w_rem_nxt  = w_hdr_rem - 17'(w_cnt);
                        w_flush    = (w_rem_nxt == 17'd0);
                        w_next     = w_flush ? ST_EOP_WAIT : ST_PAYLOAD;
                    end
                end else if (w_sync_bad) begin
                    w_sync_err = 1'b1;
                    w_next     = ST_IDLE;
                end else if (!rxactivehs[0]) begin
                    w_next = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (!rxactivehs[0] || !rxvalidhs[0]) begin
                    w_lane_err = 1'b1;
                    w_clear    = 1'b1;
                    w_rem_nxt  = 17'd0;
                    w_next     = ST_IDLE;
                end else begin
                    w_cnt      = take_bytes(r_rem, 3'd7);
                    w_append   = 1'b1;
                    w_app_data = rxdatahs;
                    w_rem_nxt  = r_rem - 17'(w_cnt);
                    w_flush    = (w_rem_nxt == 17'd0);
                    if (w_flush) w_next = ST_EOP_WAIT;
                end
            end
            ST_EOP_WAIT: begin
                w_sync_err = w_sync_bad;
                if (!rxactivehs[0]) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rxbyteclkhs) begin
        if (rxbyteclkhs_rst) begin
            r_state      <= ST_IDLE;
            r_rem        <= '0;
            r_header     <= '0;
            r_hdr_valid  <= 1'b0;
            r_short_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_lane_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_rem        <= w_rem_nxt;
            if (w_hdr_load) r_header <= rxdatahs[31:0];
            r_hdr_valid  <= w_hdr_load;
            r_short_done <= w_short;
            r_sync_err   <= w_sync_err;
            r_lane_err   <= w_lane_err;
        end
    end

    csi2rx_byte_packer u_packer (
        .clk        (rxbyteclkhs),
        .rst        (rxbyteclkhs_rst),
        .i_clear    (w_clear),
        .i_append   (w_append),
        .i_flush    (w_flush),
        .i_cnt      (w_cnt),
        .i_data     (w_app_data),
        .o_wr_en    (fifo_wr_en),
        .o_wr_data  (fifo_wr_data),
        .o_wr_bytes (fifo_wr_bytes),
        .o_wr_last  (w_pk_last)
    );

    assign fifo_wr_last = w_pk_last;
    assign packet_done  = r_short_done | w_pk_last;
    assign header_valid = r_hdr_valid;
    assign header_data  = r_header;
    assign sync_err     = r_sync_err;
    assign lane_err     = r_lane_err;

endmodule
